// File: rtl/pc_sequencer.sv
// pc_sequencer: three-state fetch/decode sequencer that owns the program
// counter. It requests instruction words, reports accepted fetches, resolves
// conditional branches and counts taken branches, with saturation at 255.
module pc_sequencer #(
    parameter int SH_IN_WIDTH = 8,
    parameter int PC_WIDTH    = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   imem_ack,
    input  logic                   br_valid,
    input  logic                   Branch,
    input  logic                   Zero,
    input  logic [SH_IN_WIDTH-1:0] ShiftIn,
    input  logic                   stall,
    output logic [PC_WIDTH-1:0]    PC,
    output logic                   imem_req,
    output logic                   fetch_valid,
    output logic                   flush,
    output logic [7:0]             taken_cnt
);

    // The shifted offset is at least as wide as the PC, so truncation to the
    // PC width happens in one place regardless of parameter choice.
    localparam int EXT_W = (SH_IN_WIDTH + 2 > PC_WIDTH) ? SH_IN_WIDTH + 2 : PC_WIDTH;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        FETCH  = 2'b01,
        DECODE = 2'b10
    } state_t;

    state_t              state_reg;
    state_t              state_next;
    logic [PC_WIDTH-1:0] pc_reg;
    logic [PC_WIDTH-1:0] pc_next;
    logic                fetch_valid_reg;
    logic                fetch_valid_next;
    logic                flush_reg;
    logic                flush_next;
    logic [7:0]          taken_cnt_reg;
    logic [7:0]          taken_cnt_next;

    logic [PC_WIDTH-1:0] pc_plus4;
    logic [EXT_W-1:0]    offset_ext;
    logic [PC_WIDTH-1:0] branch_target;
    logic                branch_taken;
    logic                taken_sat;

    // Sequential PC successor and branch target; both wrap modulo 2^PC_WIDTH.
    assign pc_plus4      = pc_reg + PC_WIDTH'(4);
    assign offset_ext    = EXT_W'({ShiftIn, 2'b00});
    assign branch_target = offset_ext[PC_WIDTH-1:0] + pc_plus4;
    assign branch_taken  = Branch & Zero;
    assign taken_sat     = (taken_cnt_reg == 8'hFF);

    // Next-state and next-register logic; pulses default low every cycle.
    always_comb begin
        state_next       = state_reg;
        pc_next          = pc_reg;
        fetch_valid_next = 1'b0;
        flush_next       = 1'b0;
        taken_cnt_next   = taken_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                if (imem_ack) begin
                    state_next       = DECODE;
                    fetch_valid_next = 1'b1;
                end
            end
            DECODE: begin
                // A stall masks br_valid entirely; the decision waits.
                if (!stall && br_valid) begin
                    state_next = FETCH;
                    if (branch_taken) begin
                        pc_next    = branch_target;
                        flush_next = 1'b1;
                        if (!taken_sat) begin
                            taken_cnt_next = taken_cnt_reg + 8'd1;
                        end
                    end else begin
                        pc_next = pc_plus4;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            pc_reg          <= '0;
            fetch_valid_reg <= 1'b0;
            flush_reg       <= 1'b0;
            taken_cnt_reg   <= 8'd0;
        end else begin
            state_reg       <= state_next;
            pc_reg          <= pc_next;
            fetch_valid_reg <= fetch_valid_next;
            flush_reg       <= flush_next;
            taken_cnt_reg   <= taken_cnt_next;
        end
    end

    // The request is a pure function of the state register.
    assign imem_req    = (state_reg == FETCH);
    assign PC          = pc_reg;
    assign fetch_valid = fetch_valid_reg;
    assign flush       = flush_reg;
    assign taken_cnt   = taken_cnt_reg;

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter SH_IN_WIDTH, default 8: branch offset width.
REQ-002 SHALL have parameter PC_WIDTH, default 6: program counter width.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: begin fetching; sampled only in IDLE.
REQ-006 SHALL have port imem_ack, input, 1 bit: instruction memory returned the word for the current PC.
REQ-007 SHALL have port br_valid, input, 1 bit: Branch/Zero/ShiftIn are valid for the fetched instruction.
REQ-008 SHALL have port Branch, input, 1 bit: instruction is a conditional branch.
REQ-009 SHALL have port Zero, input, 1 bit: ALU zero flag.
REQ-010 SHALL have port ShiftIn, input, SH_IN_WIDTH bits: unsigned branch word offset.
REQ-011 SHALL have port stall, input, 1 bit: hold the sequencer in DECODE.
REQ-012 SHALL have port PC, output, PC_WIDTH bits: current fetch address, registered.
REQ-013 SHALL have port imem_req, output, 1 bit: fetch request.
REQ-014 SHALL have port fetch_valid, output, 1 bit: one-cycle pulse marking an accepted fetch.
REQ-015 SHALL have port flush, output, 1 bit: one-cycle pulse on a taken branch.
REQ-016 SHALL have port taken_cnt, output, 8 bits: saturating count of taken branches.

Function
REQ-017 SHALL implement states IDLE, FETCH and DECODE, with imem_req = 1 only in FETCH (Moore output).
REQ-018 SHALL compute PCNext = (PC + 4) mod 2^PC_WIDTH.
REQ-019 SHALL compute target = ((ShiftIn << 2) + PCNext) truncated to PC_WIDTH bits, with the offset zero-extended before the shift.
REQ-020 In IDLE, when start = 1, SHALL go to FETCH on the next edge with PC unchanged; when start = 0, SHALL stay in IDLE.
REQ-021 In FETCH, when imem_ack = 1, SHALL go to DECODE and assert fetch_valid for exactly the following cycle; when imem_ack = 0, SHALL stay in FETCH with imem_req held at 1.
REQ-022 SHALL ignore imem_ack outside FETCH.
REQ-023 In DECODE with stall = 1, SHALL hold state and PC and ignore br_valid.
REQ-024 In DECODE with stall = 0, br_valid = 1 and Branch = 1 and Zero = 1, SHALL load PC with target, assert flush for one cycle, increment taken_cnt, and go to FETCH.
REQ-025 In DECODE with stall = 0, br_valid = 1 and not (Branch = 1 and Zero = 1), SHALL load PC with PCNext, keep flush = 0, and go to FETCH.
REQ-026 In DECODE with stall = 0 and br_valid = 0, SHALL stay in DECODE.
REQ-027 SHALL let PC wrap modulo 2^PC_WIDTH with no error indication (e.g. 60 + 4 gives 0 at PC_WIDTH = 6).
REQ-028 SHALL hold taken_cnt at 255 once reached.
REQ-029 SHALL ensure fetch_valid and flush are never asserted in the same cycle.
REQ-030 SHALL never hold a state outside the three defined states; any unused encoding SHALL go to IDLE on the next edge.

Reset
REQ-031 When rst_n = 0 at a clock edge, SHALL force state = IDLE, PC = 0, imem_req = 0, fetch_valid = 0, flush = 0 and taken_cnt = 0, overriding all other inputs.
REQ-032 When reset is applied mid-fetch or mid-decode, SHALL abandon the outstanding request with no pulse.
REQ-033 SHALL treat the first edge with rst_n = 1 as an ordinary IDLE cycle.

Verification
REQ-034 The bench SHALL check: reset, then start = 1 for one cycle, then imem_ack = 1 after 3 cycles -> imem_req high for 3 cycles plus the ack cycle, one fetch_valid pulse, PC = 0.
REQ-035 The bench SHALL check: PC = 8, br_valid = 1, Branch = 1, Zero = 1, ShiftIn = 3 -> PC = 24, flush pulses once, taken_cnt increments by 1.
REQ-036 The bench SHALL check: PC = 8, br_valid = 1, Branch = 1, Zero = 0 -> PC = 12, flush = 0, taken_cnt unchanged.
REQ-037 The bench SHALL check: PC = 60 with a not-taken branch -> PC = 0; PC = 60 with ShiftIn = 255 taken -> PC = (1020 + 0) mod 64 = 60.
REQ-038 The bench SHALL check: stall = 1 together with br_valid = 1 for 4 cycles -> state and PC frozen, then stall = 0 with br_valid = 1 -> decision applied on the first unstalled edge.
REQ-039 The bench SHALL check: rst_n = 0 asserted in FETCH with imem_ack = 1 in the same cycle -> IDLE, PC = 0, no fetch_valid pulse; and 300 taken branches -> taken_cnt = 255.
